// File: rtl/monitor_bus_master_pkg.sv
// monitor_bus_master_pkg: FSM states and bus idle levels shared by the bus master
package monitor_bus_master_pkg;
    typedef enum logic [2:0] {IDLE, ADDR_LO, ADDR_HI, DATA_LO, DATA_HI, GAP} state_t;
    localparam logic       IDLE_SLOT_X = 1'b1;
    localparam logic       IDLE_CLK_RW = 1'b1;
    localparam logic       IDLE_AX_D   = 1'b1;
    localparam logic       IDLE_R_WX   = 1'b1;
    localparam logic       IDLE_OE_X   = 1'b1;
    localparam logic [7:0] IDLE_DATA   = 8'h00;
endpackage

// File: rtl/bkm_int_sync.sv
// bkm_int_sync: two-flop synchronizer plus falling-edge detector for the card interrupt
module bkm_int_sync (
    input  logic clk_20mhz,
    input  logic reset,
    input  logic int_x,
    output logic irq_pulse
);
    logic [2:0] r_sync;
    always_ff @(posedge clk_20mhz) begin
        if (reset) r_sync <= 3'b111;
        else       r_sync <= {r_sync[1:0], int_x};
    end
    assign irq_pulse = r_sync[2] & ~r_sync[1];
endmodule

// File: rtl/monitor_bus_master.sv
// monitor_bus_master: host command to card bus sequencer with clk_rw strobe and interrupt pulse
module monitor_bus_master
    import monitor_bus_master_pkg::*;
#(
    parameter int HALF_PERIOD = 10,
    parameter int GAP_CYCLES  = 4
) (
    input  logic       clk_20mhz,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       slot_x,
    output logic       clk_rw,
    output logic       ax_d,
    output logic       r_wx,
    output logic [7:0] bus_data_out,
    output logic       bus_data_oe_x,
    input  logic [7:0] bus_data_in,
    input  logic       int_x,
    output logic       irq_pulse
);
    localparam logic [7:0] HP_LOAD  = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);
    state_t     r_state, w_next;
    logic [7:0] r_cnt, w_cnt_next, r_addr, r_wdata, r_rdata;
    logic       r_write, r_rsp_valid, w_done, w_addr_ph, w_data_ph, w_lo;
    assign w_done = r_cnt == 8'd0;
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = cmd_valid ? ADDR_LO : IDLE;
            ADDR_LO: w_next = w_done ? ADDR_HI : ADDR_LO;
            ADDR_HI: w_next = w_done ? DATA_LO : ADDR_HI;
            DATA_LO: w_next = w_done ? DATA_HI : DATA_LO;
            DATA_HI: w_next = w_done ? GAP : DATA_HI;
            GAP:     w_next = w_done ? IDLE : GAP;
            default: w_next = IDLE;
        endcase
        w_cnt_next = (w_next == r_state) ? (w_done ? 8'd0 : r_cnt - 8'd1) :
                     (w_next == GAP)     ? GAP_LOAD :
                     (w_next == IDLE)    ? 8'd0 : HP_LOAD;
    end
    always_ff @(posedge clk_20mhz) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_write     <= 1'b0;
            r_addr      <= 8'd0;
            r_wdata     <= 8'd0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 8'd0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_rsp_valid <= (r_state == DATA_HI) && w_done && !r_write;
            if (r_state == IDLE && cmd_valid) begin
                r_write <= cmd_write;
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
            end
            if (r_state == DATA_HI && w_done && !r_write) r_rdata <= bus_data_in;
        end
    end
    // bus levels depend only on the state, so they can only move on state entry
    assign w_addr_ph     = (r_state == ADDR_LO) || (r_state == ADDR_HI);
    assign w_data_ph     = (r_state == DATA_LO) || (r_state == DATA_HI);
    assign w_lo          = (r_state == ADDR_LO) || (r_state == DATA_LO);
    assign cmd_ready     = (r_state == IDLE) && !reset;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rdata;
    assign slot_x        = (w_addr_ph || w_data_ph) ? 1'b0 : IDLE_SLOT_X;
    assign clk_rw        = w_lo ? 1'b0 : (w_addr_ph || w_data_ph) ? 1'b1 : IDLE_CLK_RW;
    assign ax_d          = w_addr_ph ? 1'b1 : w_data_ph ? 1'b0 : IDLE_AX_D;
    assign r_wx          = w_addr_ph ? 1'b0 : w_data_ph ? ~r_write : IDLE_R_WX;
    assign bus_data_out  = w_addr_ph ? r_addr : (w_data_ph && r_write) ? r_wdata : IDLE_DATA;
    assign bus_data_oe_x = (w_addr_ph || (w_data_ph && r_write)) ? 1'b0 : IDLE_OE_X;
    bkm_int_sync u_int_sync (
        .clk_20mhz(clk_20mhz),
        .reset    (reset),
        .int_x    (int_x),
        .irq_pulse(irq_pulse)
    );
endmodule

// File: tb/tb_monitor_bus_master.sv
// tb_monitor_bus_master: directed vectors and corner sequences for monitor_bus_master
module tb_monitor_bus_master;
    logic       clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, cmd_write = 1'b0, int_x = 1'b1;
    logic [7:0] cmd_addr = 8'd0, cmd_wdata = 8'd0, card = 8'd0;
    logic       cmd_ready, rsp_valid, slot_x, clk_rw, ax_d, r_wx, bus_data_oe_x, irq_pulse;
    logic [7:0] rsp_rdata, bus_data_out, bus_data_in;
    int         total = 0, bad = 0;

    typedef struct {
        logic       wr;
        logic [7:0] addr, wdata, card;
        int         exp_rsp;
        logic [7:0] exp_rdata;
        logic       exp_rwx, exp_oe;
    } vec_t;
    vec_t vecs[5];

    always #25 clk = ~clk;
    // card drives its register value only while the data phase strobe is high
    assign bus_data_in = (!slot_x && !ax_d && clk_rw) ? card : 8'hEE;

    monitor_bus_master dut (
        .clk_20mhz(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .slot_x(slot_x), .clk_rw(clk_rw),
        .ax_d(ax_d), .r_wx(r_wx), .bus_data_out(bus_data_out), .bus_data_oe_x(bus_data_oe_x),
        .bus_data_in(bus_data_in), .int_x(int_x), .irq_pulse(irq_pulse)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int   slow = 0, rise1 = -1, rise2 = -1, rsp = 0, rsp_at = -1, chg = 0;
        logic prev_clk = 1'b1, prev_slot = 1'b1;
        logic [10:0] prev_bus = '0;
        logic [7:0]  rd = 8'd0;
        card = v.card;
        @(negedge clk);
        chk("ready_before", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            if (k > 1) @(negedge clk);
            if (!slot_x) slow++;
            if (clk_rw && !prev_clk && !slot_x) begin
                if (rise1 < 0) begin
                    rise1 = k - 1;
                    chk("addr_phase", {21'd0, ax_d, r_wx, bus_data_oe_x, bus_data_out}, {21'd0, 1'b1, 1'b0, 1'b0, v.addr});
                end else begin
                    rise2 = k - 1;
                    chk("data_ctl", {29'd0, ax_d, r_wx, bus_data_oe_x}, {29'd0, 1'b0, v.exp_rwx, v.exp_oe});
                    if (!v.exp_oe) chk("data_bus", 32'(bus_data_out), 32'(v.wdata));
                end
            end
            if (clk_rw && prev_clk && !slot_x && !prev_slot && {ax_d, r_wx, bus_data_oe_x, bus_data_out} != prev_bus) chg++;
            if (rsp_valid) begin rsp++; rsp_at = k; rd = rsp_rdata; end
            if (k == 42) chk("idle_after", {19'd0, slot_x, clk_rw, ax_d, r_wx, bus_data_oe_x, bus_data_out}, {19'd0, 5'b11111, 8'h00});
            if (k == 44) chk("ready_gap", 32'(cmd_ready), 32'd0);
            if (k == 45) chk("ready_idle", 32'(cmd_ready), 32'd1);
            prev_clk = clk_rw; prev_slot = slot_x; prev_bus = {ax_d, r_wx, bus_data_oe_x, bus_data_out};
        end
        chk("slot_low_cycles", 32'(slow), 32'd40);
        chk("rise_addr", 32'(rise1), 32'd10);
        chk("rise_data", 32'(rise2), 32'd30);
        chk("change_while_high", 32'(chg), 32'd0);
        chk("rsp_count", 32'(rsp), 32'(v.exp_rsp));
        if (v.exp_rsp == 1) begin
            chk("rsp_cycle", 32'(rsp_at), 32'd41);
            chk("rsp_rdata", 32'(rd), 32'(v.exp_rdata));
        end
    endtask

    task automatic irq_episode(input string nm, input int low_cycles);
        int first = -1, cnt = 0, late = 0;
        int_x = 1'b0;
        for (int i = 1; i <= low_cycles; i++) begin
            @(negedge clk);
            if (irq_pulse) begin cnt++; if (first < 0) first = i; end
        end
        int_x = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (irq_pulse) late++;
        end
        chk({nm, "_pulses"}, 32'(cnt), 32'd1);
        chk({nm, "_latency"}, 32'(first >= 1 && first <= 3), 32'd1);
        chk({nm, "_rise_quiet"}, 32'(late), 32'd0);
    endtask

    initial begin
        int n1, n2, lowcnt, rsp;
        logic prev_slot;
        vecs[0] = '{1'b1, 8'h12, 8'hA5, 8'h00, 0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h03, 8'h00, 8'h5C, 1, 8'h5C, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 8'hFF, 8'h3C, 8'h33, 0, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h80, 8'h77, 8'hA3, 1, 8'hA3, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 8'hFF, 8'hFF, 1, 8'hFF, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(cmd_ready), 32'd0);
        chk("reset_bus", {19'd0, slot_x, clk_rw, ax_d, r_wx, bus_data_oe_x, bus_data_out}, {19'd0, 5'b11111, 8'h00});
        chk("reset_rsp", {22'd0, rsp_valid, rsp_rdata, irq_pulse}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // back-to-back with cmd_valid held high
        card = 8'h00;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h12; cmd_wdata = 8'hA5;
        n1 = -1; n2 = -1; lowcnt = 0; prev_slot = 1'b1;
        for (int n = 1; n <= 150 && n2 < 0; n++) begin
            @(negedge clk);
            if (!slot_x && prev_slot) begin if (n1 < 0) n1 = n; else n2 = n; end
            if (n1 >= 0 && n2 < 0 && !cmd_ready) lowcnt++;
            prev_slot = slot_x;
        end
        cmd_valid = 1'b0;
        chk("b2b_ready_low", 32'(lowcnt), 32'd44);
        chk("b2b_spacing", 32'(n2 - n1), 32'd45);
        for (int n = 0; n < 100 && !cmd_ready; n++) @(negedge clk);
        chk("b2b_ready_return", 32'(cmd_ready), 32'd1);

        // reset in DATA_LO of a read
        card = 8'h99;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h44;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (24) @(negedge clk);
        chk("in_data_lo", {29'd0, slot_x, ax_d, clk_rw}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_slot", {30'd0, slot_x, rsp_valid}, {30'd0, 1'b1, 1'b0});
        reset = 1'b0;
        rsp = 0;
        repeat (50) begin @(negedge clk); if (rsp_valid) rsp++; end
        chk("abort_no_rsp", 32'(rsp), 32'd0);
        run_txn(vecs[0]);

        irq_episode("irq_idle", 100);
        fork
            run_txn(vecs[1]);
            begin
                repeat (8) @(negedge clk);
                irq_episode("irq_busy", 20);
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
